// File: rtl/demux_pkg.sv
// Shared constants for the round-robin demux scheduler.
// Optional feature macro: DEMUX_SCHED_MASK_EN (adds the ch_mask port on the top).
package demux_pkg;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned HOLD_W = 8;

  // Scheduler FSM encodings
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set bit of eligible scanning
// ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
  import demux_pkg::*;
(
  input  logic [N_CH-1:0]  eligible,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_any
);

  logic [SEL_W-1:0] idx;

  // Rotating priority scan starting at ptr; first hit wins
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = SEL_W'(ptr + i);
      if (!grant_any && eligible[idx]) begin
        grant     = idx;
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler steering a valid/ready stream onto a 1:4 demux.
// Each accepted word is held on d_in/d_sel/out_valid for HOLD_CYCLES cycles.
// Optional feature macro: DEMUX_SCHED_MASK_EN (adds ch_mask; eligible = ch_ready & ch_mask).
module demux_rr_sched
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [N_CH-1:0]  ch_ready,
`ifdef DEMUX_SCHED_MASK_EN
  input  logic [N_CH-1:0]  ch_mask,
`endif
  output logic [WIDTH-1:0] d_in,
  output logic [SEL_W-1:0] d_sel,
  output logic [N_CH-1:0]  out_valid,
  output logic             busy
);

  logic [0:0]        state;
  logic [SEL_W-1:0]  ptr;
  logic [HOLD_W-1:0] cnt;
  logic [N_CH-1:0]   eligible;
  logic [SEL_W-1:0]  grant;
  logic              grant_any;
  logic              accept;

  // Channels that may take a word this cycle
  always_comb begin
`ifdef DEMUX_SCHED_MASK_EN
    eligible = ch_ready & ch_mask;
`else
    eligible = ch_ready;
`endif
  end

  rr_pick4 u_pick (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_any (grant_any)
  );

  // Handshake and status; in_ready is forced low while reset is asserted
  always_comb begin
    in_ready = ~rst && (state == IDLE) && grant_any;
    accept   = in_valid && in_ready;
    busy     = (state == XFER);
  end

  // FSM, round-robin pointer, hold counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      d_in      <= '0;
      d_sel     <= '0;
      out_valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            d_in      <= in_data;
            d_sel     <= grant;
            out_valid <= N_CH'(1) << grant;
            ptr       <= grant + 1'b1;
            cnt       <= HOLD_W'(HOLD_CYCLES - 1);
            state     <= XFER;
          end else begin
            out_valid <= '0;
          end
        end
        default: begin
          if (cnt == '0) begin
            out_valid <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: two instances (HOLD_CYCLES=1 and 4) share the
// stimulus; each is compared every cycle against a transfer-level model.
module tb_demux_rr_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [3:0]   ch_ready;
  logic [3:0]   ch_mask = 4'hF;

  logic         in_ready_w [2];
  logic [W-1:0] d_in_w     [2];
  logic [1:0]   d_sel_w    [2];
  logic [3:0]   ov_w       [2];
  logic         busy_w     [2];

  int n_tests = 0;
  int n_fail  = 0;

  int hold [2] = '{1, 4};

  // Reference state per instance
  int           m_ptr  [2];
  int           m_left [2];
  logic [W-1:0] m_din  [2];
  int           m_sel  [2];
  logic [3:0]   m_ov   [2];

  always #5 clk = ~clk;

  demux_rr_sched #(.WIDTH(W), .HOLD_CYCLES(1)) u_h1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_w[0]),
    .ch_ready  (ch_ready),
`ifdef DEMUX_SCHED_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .d_in      (d_in_w[0]),
    .d_sel     (d_sel_w[0]),
    .out_valid (ov_w[0]),
    .busy      (busy_w[0])
  );

  demux_rr_sched #(.WIDTH(W), .HOLD_CYCLES(4)) u_h4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_w[1]),
    .ch_ready  (ch_ready),
`ifdef DEMUX_SCHED_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .d_in      (d_in_w[1]),
    .d_sel     (d_sel_w[1]),
    .out_valid (ov_w[1]),
    .busy      (busy_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] elig();
`ifdef DEMUX_SCHED_MASK_EN
    return ch_ready & ch_mask;
`else
    return ch_ready;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i]  = 0;
      m_left[i] = 0;
      m_din[i]  = '0;
      m_sel[i]  = 0;
      m_ov[i]   = '0;
    end
  endtask

  // One rising edge worth of behaviour, using the inputs present before it
  task automatic model_edge();
    logic [3:0] e;
    bit found;
    int c;
    if (rst) begin
      model_reset();
      return;
    end
    e = elig();
    for (int i = 0; i < 2; i++) begin
      if (m_left[i] == 0) begin
        m_ov[i] = '0;
        if (in_valid && e != 4'b0) begin
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            c = (m_ptr[i] + k) % 4;
            if (!found && e[c]) begin
              found     = 1'b1;
              m_sel[i]  = c;
              m_din[i]  = in_data;
              m_ov[i]   = 4'(1 << c);
              m_ptr[i]  = (c + 1) % 4;
              m_left[i] = hold[i];
            end
          end
        end
      end else begin
        m_left[i]--;
        if (m_left[i] == 0) m_ov[i] = '0;
      end
    end
  endtask

  task automatic check_ready();
    for (int i = 0; i < 2; i++)
      check($sformatf("h%0d_in_ready", hold[i]), 32'(in_ready_w[i]),
            32'(!rst && m_left[i] == 0 && elig() != 4'b0));
  endtask

  task automatic check_out();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("h%0d_d_in", hold[i]),      32'(d_in_w[i]),  32'(m_din[i]));
      check($sformatf("h%0d_d_sel", hold[i]),     32'(d_sel_w[i]), 32'(m_sel[i]));
      check($sformatf("h%0d_out_valid", hold[i]), 32'(ov_w[i]),    32'(m_ov[i]));
      check($sformatf("h%0d_busy", hold[i]),      32'(busy_w[i]),  32'(m_left[i] > 0));
    end
  endtask

  // Inputs are set by the caller just after an edge; one full cycle follows
  task automatic step();
    #1;
    check_ready();
    @(posedge clk);
    model_edge();
    #1;
    check_out();
  endtask

  // Reset pulse placed between clock edges; outputs must clear immediately
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_ready();
    check_out();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] pat [5];
    pat = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd1};
    model_reset();

    // Reset held with an eager producer and all channels ready
    rst = 1'b1; in_valid = 1'b1; ch_ready = 4'hF; in_data = 8'hA5;
    repeat (3) step();
    rst = 1'b0;

    // All channels ready, continuous traffic
    for (int k = 0; k < 12; k++) begin
      in_data = (k < 5) ? pat[k] : W'($urandom);
      step();
    end

    // Only channels 0 and 2 ready
    ch_ready = 4'b0101;
    for (int k = 0; k < 12; k++) begin
      in_data = W'($urandom);
      step();
    end

    // Nothing ready, then only channel 3
    ch_ready = 4'b0000;
    repeat (5) step();
    ch_ready = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      in_data = W'($urandom);
      step();
    end

    // Drain, accept one word, then drop ch_ready during the transfer
    in_valid = 1'b0; ch_ready = 4'hF;
    repeat (6) step();
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    step();
    ch_ready = 4'b0000;
    repeat (5) step();

    // Repeat run interrupted by a mid-transfer reset
    ch_ready = 4'hF; in_valid = 1'b1; in_data = 8'hC3;
    step();
    in_valid = 1'b0;
    step();
    step();
    async_reset();
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    repeat (6) step();

`ifdef DEMUX_SCHED_MASK_EN
    // Channel 0 masked off, then everything masked
    ch_mask = 4'b1110; ch_ready = 4'hF; in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_data = W'($urandom);
      step();
    end
    ch_mask = 4'b0000;
    repeat (6) step();
    ch_mask = 4'hF;
`endif

    // Randomised traffic with occasional asynchronous resets
    for (int k = 0; k < 400; k++) begin
      ch_ready = 4'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
`ifdef DEMUX_SCHED_MASK_EN
      ch_mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
`endif
      step();
      if ($urandom_range(0, 60) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
